// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: step modes and FSM state encoding.
package shift_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_LSR = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LSL = 3'd1;
  localparam logic [MODE_W-1:0] MODE_ASR = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle of the universal shift register; master drives, slave is the register.
interface universal_shift_register_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             ena;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [2:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output load, data, ena, start, count, mode, sin,
    input  q, sout, busy, done
  );

  modport slave (
    input  load, data, ena, start, count, mode, sin,
    output q, sout, busy, done
  );
endinterface

// File: rtl/shift_step.sv
// One combinational shift/rotate step; shared by the single-step and burst paths.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]  q_cur,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin,
  input  logic              sout_cur,
  output logic [WIDTH-1:0]  q_next,
  output logic              sout_next
);

  always_comb begin
    q_next    = q_cur;
    sout_next = sout_cur;
    case (mode)
      MODE_LSR: begin
        q_next    = {sin, q_cur[WIDTH-1:1]};
        sout_next = q_cur[0];
      end
      MODE_LSL: begin
        q_next    = {q_cur[WIDTH-2:0], sin};
        sout_next = q_cur[WIDTH-1];
      end
      MODE_ASR: begin
        q_next    = {q_cur[WIDTH-1], q_cur[WIDTH-1:1]};
        sout_next = q_cur[0];
      end
      MODE_ROR: begin
        q_next    = {q_cur[0], q_cur[WIDTH-1:1]};
        sout_next = q_cur[0];
      end
      MODE_ROL: begin
        q_next    = {q_cur[WIDTH-2:0], q_cur[WIDTH-1]};
        sout_next = q_cur[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift/rotate register with parallel load, single-step shifting and
// autonomous counted bursts reported through busy/done.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic clk,
  input logic reset,
  universal_shift_register_if.slave bus
);

  state_e            state_q;
  logic [CNT_W-1:0]  rem_q;
  logic [MODE_W-1:0] mode_q;
  logic [WIDTH-1:0]  q_q;
  logic              sout_q;
  logic              done_q;

  logic [MODE_W-1:0] step_mode;
  logic [WIDTH-1:0]  step_q;
  logic              step_sout;

  // Bursts use the mode captured at start; single steps use the live mode.
  assign step_mode = (state_q == ST_RUN) ? mode_q : bus.mode;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q_cur     (q_q),
    .mode      (step_mode),
    .sin       (bus.sin),
    .sout_cur  (sout_q),
    .q_next    (step_q),
    .sout_next (step_sout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= MODE_LSR;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        // Load also aborts a running burst without signalling done.
        q_q     <= bus.data;
        state_q <= ST_IDLE;
        rem_q   <= '0;
      end else if (state_q == ST_RUN) begin
        q_q    <= step_q;
        sout_q <= step_sout;
        rem_q  <= rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
      end else if (bus.start) begin
        if (bus.count == '0) begin
          done_q <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          rem_q   <= bus.count;
          mode_q  <= bus.mode;
        end
      end else if (bus.ena) begin
        q_q    <= step_q;
        sout_q <= step_sout;
      end
    end
  end

  assign bus.q    = q_q;
  assign bus.sout = sout_q;
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = done_q;

endmodule
